// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared definitions for the stream arbiter/mux slice: lock state encoding
// and the default channel geometry used by stream_arb_mux and rr_arbiter.
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;

    // UNLOCKED: the next grant comes from the round-robin search.
    // LOCKED:   a packet is in flight and only its channel may be granted.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. It picks the first requesting
// channel, looking at ptr, ptr+1, ..., NUM_CH-1, 0, ... in that order.
//
// Ports:
//   req     [NUM_CH] : per-channel request
//   ptr     [SEL_W]  : highest-priority channel; must be < NUM_CH
//   gnt     [SEL_W]  : index of the granted channel; 0 when nothing requests
//   any_req          : at least one channel is requesting
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              any_req
);

    int               w_idx;
    logic [SEL_W-1:0] w_idx_sel;

    // NOTE: every output of a combinational block gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt       = '0;
        any_req   = 1'b0;
        w_idx     = 0;
        w_idx_sel = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            // Modulo by subtraction: ptr < NUM_CH, so a single wrap suffices
            // and NUM_CH need not be a power of two.
            w_idx = int'(ptr) + off;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            w_idx_sel = SEL_W'(w_idx);
            if (!any_req && req[w_idx_sel]) begin
                gnt     = w_idx_sel;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// -----------------------------------------------------------------------------
// stream_arb_mux
// Packet-aware N:1 stream multiplexer. Channels are served round robin at
// packet granularity: once a non-last beat is accepted, the channel keeps the
// grant until its last beat has gone through. The output stage is a single
// register slice with valid/ready handshake.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   [NUM_CH]       : per-channel beat valid
//   in_data    [NUM_CH*WIDTH] : channel i at [i*WIDTH +: WIDTH]
//   in_last    [NUM_CH]       : per-channel end-of-packet flag
//   in_ready   [NUM_CH]       : per-channel accept, one-hot or zero
//   out_valid                 : output beat valid (registered)
//   out_data   [WIDTH]        : output beat data (registered)
//   out_last                  : output end-of-packet (registered)
//   out_ch     [SEL_W]        : source channel of the output beat
//   out_ready                 : downstream accept
// -----------------------------------------------------------------------------
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    input  logic                    out_ready
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH * WIDTH);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_cur;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [SEL_W-1:0] r_out_ch;

    logic [SEL_W-1:0] w_rr_gnt;
    logic             w_rr_any;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_valid;
    logic             w_load;
    logic             w_accept;
    logic             w_gnt_last;
    logic [IDX_W-1:0] w_base;
    logic [SEL_W-1:0] w_ptr_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .any_req (w_rr_any)
    );

    // While locked, the other channels are invisible; the search result is
    // only used between packets.
    assign w_gnt       = (r_state == ST_LOCKED) ? r_cur : w_rr_gnt;
    assign w_gnt_valid = (r_state == ST_LOCKED) ? in_valid[r_cur] : w_rr_any;

    // The output slice can take a new beat when it is empty or draining.
    assign w_load   = !r_out_valid || out_ready;
    // rst_n gates the accept so in_ready stays low for the whole reset cycle
    // and no beat is consumed that the reset would then discard.
    assign w_accept = rst_n && w_load && w_gnt_valid;

    assign w_gnt_last = in_last[w_gnt];
    assign w_base     = IDX_W'(w_gnt) * IDX_W'(WIDTH);
    assign w_ptr_next = (w_gnt == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            // A last beat releases the lock, including a single-beat packet
            // accepted while unlocked.
            w_state_next = w_gnt_last ? ST_UNLOCKED : ST_LOCKED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data registers are reset as well: out_data/out_last/out_ch read as zero
    // after reset, not merely don't-care behind out_valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_cur       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_base +: WIDTH];
            r_out_last  <= w_gnt_last;
            r_out_ch    <= w_gnt;
            if (w_gnt_last) begin
                r_ptr <= w_ptr_next;
            end else begin
                r_cur <= w_gnt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel, >=1.
REQ-002 SHALL have parameter NUM_CH, default 4: input channel count, >=2, power of two not required.
REQ-003 SHALL have localparam SEL_W = $clog2(NUM_CH): channel-index width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, NUM_CH: per-channel beat valid.
REQ-007 SHALL have port in_data, input, NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last, input, NUM_CH: per-channel end-of-packet flag.
REQ-009 SHALL have port in_ready, output, NUM_CH: per-channel accept; at most one bit high per cycle.
REQ-010 SHALL have port out_valid, output, 1: registered output beat valid.
REQ-011 SHALL have port out_data, output, WIDTH: registered output data.
REQ-012 SHALL have port out_last, output, 1: registered end-of-packet flag.
REQ-013 SHALL have port out_ch, output, SEL_W: source channel of the current output beat.
REQ-014 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-015 SHALL transfer a beat on channel i only in a cycle where in_valid[i] && in_ready[i].
REQ-016 SHALL define load = !out_valid || out_ready; in_ready[g] = load && in_valid[g] for granted channel g, and all other in_ready bits 0.
REQ-017 SHALL, when unlocked, grant the first channel with in_valid set, searching ptr, ptr+1, ..., NUM_CH-1, 0, ... (round robin).
REQ-018 SHALL, when locked, grant only the locked channel cur, ignoring all other in_valid.
REQ-019 SHALL register an accepted beat into out_data/out_last/out_ch with out_valid=1 on the next edge: latency exactly 1 cycle.
REQ-020 SHALL hold out_valid, out_data, out_last and out_ch stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on an edge where out_valid && out_ready and no new beat is accepted.
REQ-022 SHALL sustain 1 beat/cycle while out_ready stays high and the granted channel stays valid.
REQ-023 SHALL, on accepting a non-last beat while unlocked, enter LOCKED with cur = granted channel.
REQ-024 SHALL, on accepting a last beat, return to or stay UNLOCKED and set ptr = granted+1, wrapping NUM_CH-1 -> 0.
REQ-025 SHALL leave ptr unchanged while locked, and when unlocked with no beat accepted.
REQ-026 SHALL treat a single-beat packet (in_last=1 on the first beat) as an immediate lock release.
REQ-027 SHALL keep the lock through gaps where in_valid[cur]=0; no timeout, no preemption.
REQ-028 SHALL ignore in_valid of channels not granted; dropping valid before acceptance is legal and loses no data.

Reset
REQ-029 SHALL, when rst_n=0 at an edge, set out_valid=0, out_data=0, out_last=0, out_ch=0, ptr=0 and state UNLOCKED.
REQ-030 SHALL drive in_ready all-zero in any cycle where rst_n=0.
REQ-031 SHALL abandon a partially transferred packet on reset mid-packet, with no replay.

Structure
REQ-032 SHALL place the UNLOCKED/LOCKED state enum and default WIDTH/NUM_CH constants in package stream_arb_pkg.
REQ-033 SHALL implement round-robin selection in sub-module rr_arbiter: combinational, inputs req[NUM_CH] and ptr, outputs gnt index and any_req.
REQ-034 SHALL implement the data path as an indexed part-select mux on in_data at the grant index.

Verification
REQ-035 SHALL test NUM_CH=4, out_ready=1, all channels valid with single-beat packets -> out_ch sequence 0,1,2,3,0, one beat per cycle, first out_valid one cycle after the first accept.
REQ-036 SHALL test ch1 sending a 3-beat packet while ch0 and ch2 are valid -> three consecutive ch1 beats, out_last only on the third, then ch2 granted.
REQ-037 SHALL test out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0 throughout; the transfer resumes on the cycle out_ready rises.
REQ-038 SHALL test NUM_CH=3 with ptr=2 and a last beat accepted on ch2 -> ptr wraps to 0.
REQ-039 SHALL test rst_n=0 during the second beat of a locked packet -> outputs cleared next edge, state UNLOCKED, ptr=0, and ch0 granted first after release.
